// File: rtl/fetch_unit.sv
// IF stage: PC register, bimodal BHT predictor and IF/ID pipeline register.
// Redirects on EX-resolved mispredicts and ID-resolved jr, obeys hazard-unit stall/flush.
module fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                BHT_IDX_W  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [6:0]        BRANCH_OPC = 7'b1100011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_Write,
    input  logic              if_id_Write,
    input  logic              if_id_flush,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              ex_is_branch,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] jr_target,
    output logic              Wrong_prediction,
    output logic [31:0]       if_id_inst,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_pred_taken,
    output logic              if_id_valid
);

    localparam int          BHT_N    = 1 << BHT_IDX_W;
    localparam logic [31:0] NOP_INST = 32'h00000013;

    logic [ADDR_W-1:0]    pc_reg;
    logic [ADDR_W-1:0]    pc_next;
    logic [ADDR_W-1:0]    pc_plus4;
    logic [ADDR_W-1:0]    ex_fallthrough;
    logic [ADDR_W-1:0]    b_imm;
    logic [ADDR_W-1:0]    pred_target;
    logic [BHT_IDX_W-1:0] fetch_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [1:0]           bht_cur [BHT_N];
    logic [1:0]           upd_old;
    logic [1:0]           upd_new;
    logic                 is_branch_op;
    logic                 pred_taken;
    logic                 wrong_pred;

    logic [31:0]          if_id_inst_reg;
    logic [ADDR_W-1:0]    if_id_pc_reg;
    logic                 if_id_pred_reg;
    logic                 if_id_valid_reg;

    assign wrong_pred       = ex_is_branch && (ex_taken != ex_pred_taken);
    assign Wrong_prediction = wrong_pred;

    assign fetch_idx = pc_reg[BHT_IDX_W+1:2];
    assign upd_idx   = ex_pc[BHT_IDX_W+1:2];

    // B-type immediate: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7]
    assign b_imm = {{(ADDR_W-12){imem_rdata[31]}}, imem_rdata[7],
                    imem_rdata[30:25], imem_rdata[11:8], 1'b0};

    assign is_branch_op   = (imem_rdata[6:0] == BRANCH_OPC);
    assign pred_taken     = is_branch_op && bht_cur[fetch_idx][1];
    assign pred_target    = pc_reg + b_imm;
    assign pc_plus4       = pc_reg + ADDR_W'(4);
    assign ex_fallthrough = ex_pc + ADDR_W'(4);

    assign upd_old = bht_cur[upd_idx];

    always_comb begin
        upd_new = upd_old;
        if (ex_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    // Each counter is its own register so reset can preset every entry to weakly not-taken
    for (genvar gi = 0; gi < BHT_N; gi++) begin : g_bht
        localparam logic [BHT_IDX_W-1:0] ENTRY_IDX = BHT_IDX_W'(gi);
        logic [1:0] ctr_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ctr_reg <= 2'b01;
            end else if (ex_is_branch && (upd_idx == ENTRY_IDX)) begin
                ctr_reg <= upd_new;
            end
        end

        assign bht_cur[gi] = ctr_reg;
    end

    // The older EX branch outranks the younger jr; jr in turn overrides a stall
    always_comb begin
        pc_next = pc_reg;
        if (wrong_pred) begin
            pc_next = ex_taken ? ex_target : ex_fallthrough;
        end else if (jr_valid) begin
            pc_next = jr_target;
        end else if (!PC_Write) begin
            pc_next = pc_reg;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_inst_reg  <= NOP_INST;
            if_id_pc_reg    <= '0;
            if_id_pred_reg  <= 1'b0;
            if_id_valid_reg <= 1'b0;
        end else if (wrong_pred || if_id_flush) begin
            if_id_inst_reg  <= NOP_INST;
            if_id_pc_reg    <= '0;
            if_id_pred_reg  <= 1'b0;
            if_id_valid_reg <= 1'b0;
        end else if (if_id_Write) begin
            if_id_inst_reg  <= imem_rdata;
            if_id_pc_reg    <= pc_reg;
            if_id_pred_reg  <= pred_taken;
            if_id_valid_reg <= 1'b1;
        end
    end

    assign imem_addr        = pc_reg;
    assign if_id_inst       = if_id_inst_reg;
    assign if_id_pc         = if_id_pc_reg;
    assign if_id_pred_taken = if_id_pred_reg;
    assign if_id_valid      = if_id_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural IF-stage model pushes the expected
// IF/ID contents each cycle; they are popped and compared one clock later.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
        logic        valid;
    } ifid_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_Write, if_id_Write, if_id_flush;
    logic [31:0] imem_addr, imem_rdata;
    logic        ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic        Wrong_prediction;
    logic [31:0] if_id_inst, if_id_pc;
    logic        if_id_pred_taken, if_id_valid;

    logic [31:0] imem [64];
    int          m_bht [16];
    logic [31:0] m_pc;
    ifid_t       m_if;
    ifid_t       sb_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[7:2]];

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .PC_Write(PC_Write), .if_id_Write(if_id_Write), .if_id_flush(if_id_flush),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_pred_taken(ex_pred_taken),
        .ex_pc(ex_pc), .ex_target(ex_target),
        .jr_valid(jr_valid), .jr_target(jr_target),
        .Wrong_prediction(Wrong_prediction),
        .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
        .if_id_pred_taken(if_id_pred_taken), .if_id_valid(if_id_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_beq(input logic [12:0] imm);
        logic [31:0] w;
        w = 32'h00000063;
        w[31]    = imm[12];
        w[7]     = imm[11];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        return w;
    endfunction

    function automatic logic [31:0] dec_beq(input logic [31:0] w);
        int v;
        v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 16; i++) m_bht[i] = 1;
        m_if = '{inst: NOP, pc: 32'h0, pred: 1'b0, valid: 1'b0};
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_inst"},  if_id_inst, NOP);
        chk({tag, "_pc"},    if_id_pc, 32'h0);
        chk({tag, "_pred"},  32'(if_id_pred_taken), 32'h0);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        chk({tag, "_wp"},    32'(Wrong_prediction), 32'h0);
    endtask

    // Called at posedge+1; drives one cycle, checks fetch side mid-cycle, IF/ID after the edge
    task automatic step(input string tag, input logic pcw, input logic ifw, input logic fl,
                        input logic exb, input logic ext, input logic expd,
                        input logic [31:0] expc, input logic [31:0] extg,
                        input logic jrv, input logic [31:0] jrt);
        logic [31:0] inst, npc;
        logic        pred, wp;
        int          idx;
        ifid_t       nxt, got;
        PC_Write = pcw; if_id_Write = ifw; if_id_flush = fl;
        ex_is_branch = exb; ex_taken = ext; ex_pred_taken = expd;
        ex_pc = expc; ex_target = extg; jr_valid = jrv; jr_target = jrt;
        #3;
        inst = imem[m_pc[7:2]];
        idx  = int'(m_pc[5:2]);
        pred = (inst[6:0] == 7'b1100011) && (m_bht[idx] >= 2);
        wp   = exb && (ext != expd);
        chk({tag, "_imem_addr"}, imem_addr, m_pc);
        chk({tag, "_wrong_pred"}, 32'(Wrong_prediction), 32'(wp));
        if (wp)        npc = ext ? extg : expc + 32'd4;
        else if (jrv)  npc = jrt;
        else if (!pcw) npc = m_pc;
        else if (pred) npc = m_pc + dec_beq(inst);
        else           npc = m_pc + 32'd4;
        if (wp || fl)  nxt = '{inst: NOP, pc: 32'h0, pred: 1'b0, valid: 1'b0};
        else if (ifw)  nxt = '{inst: inst, pc: m_pc, pred: pred, valid: 1'b1};
        else           nxt = m_if;
        sb_q.push_back(nxt);
        if (exb) begin
            idx = int'(expc[5:2]);
            if (ext) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else     m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({tag, "_if_id_inst"},  if_id_inst, got.inst);
        chk({tag, "_if_id_pc"},    if_id_pc, got.pc);
        chk({tag, "_if_id_pred"},  32'(if_id_pred_taken), 32'(got.pred));
        chk({tag, "_if_id_valid"}, 32'(if_id_valid), 32'(got.valid));
        $display("%-10s fetch=%h wp=%0b -> next=%h if_id{inst=%h pc=%h pred=%0b valid=%0b}",
                 tag, m_pc, wp, npc, if_id_inst, if_id_pc, if_id_pred_taken, if_id_valid);
        m_if = nxt;
        m_pc = npc;
    endtask

    task automatic run(input string tag, input logic pcw, input logic ifw);
        step(tag, pcw, ifw, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic jump(input string tag, input logic [31:0] t);
        step(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, t);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = NOP;
        imem[4] = enc_beq(13'h030);
        imem[8] = enc_beq(13'h008);
        model_reset();
        rst = 1'b0;
        PC_Write = 1'b0; if_id_Write = 1'b0; if_id_flush = 1'b0;
        ex_is_branch = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = 32'h0; ex_target = 32'h0; jr_valid = 1'b0; jr_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;

        run("seq0", 1'b1, 1'b1);
        run("seq4", 1'b1, 1'b1);
        run("stall8", 1'b0, 1'b0);
        run("seq8", 1'b1, 1'b1);
        run("seqC", 1'b1, 1'b1);

        step("mispred", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h40, 1'b0, 32'h0);
        jump("jr10", 32'h10);
        run("pred10", 1'b1, 1'b1);
        run("at40", 1'b1, 1'b1);

        jump("jr20", 32'h20);
        for (int i = 0; i < 4; i++)
            step("sat_up", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h28, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++)
            step("sat_dn", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h28, 1'b0, 32'h0);
        run("sat_obs", 1'b0, 1'b1);
        step("sat_inc", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h28, 1'b0, 32'h0);
        run("sat_obs2", 1'b0, 1'b1);

        step("jr_stall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h80);
        step("wp_vs_jr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h50, 1'b1, 32'h80);
        step("flush", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 30; i++) begin
            logic exb_r;
            exb_r = ($urandom_range(0, 3) == 0);
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), exb_r, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                 32'($urandom_range(0, 63)) << 2, ($urandom_range(0, 7) == 0),
                 32'($urandom_range(0, 63)) << 2);
        end

        jump("jr24", 32'h24);
        chk("pre_reset_pc", imem_addr, 32'h24);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        jump("jr10b", 32'h10);
        run("bht_rst", 1'b1, 1'b1);
        run("after", 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
